aes_core_arb: RTL
=================

# aes_core_arb

Arbiter and sequencer that shares one `aes_fsm`-style AES core between two requesters. It grants the core round-robin and drives the core's `data_stable`/`key_ready` inputs for the owning requester. It monitors `finished` and the round-type strobes, and returns a per-requester done or error pulse. It sits between the two AES client ports and the single core instance, with a watchdog guarding against a hung core.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum RUN cycles before abort; legal range 2..127.
- `ROUNDS`, default 10: expected count of mid-round cycles per operation (AES-128).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 2: per-requester operation request, level; held until done/error.
- `key_valid` in 2: requester's round key is available.
- `grant` out 2: one-hot owner; 00 when idle.
- `done` out 2: one-cycle pulse to the owner on successful completion.
- `error` out 2: one-cycle pulse to the owner on timeout or round-count mismatch.
- `busy` out 1: high in any state except IDLE.
- `core_data_stable` out 1: drives the core's `data_stable`.
- `core_key_ready` out 1: drives the core's `key_ready`.
- `core_finished` in 1: the core's `finished`.
- `core_round_type_sel` in 2: the core's `round_type_sel`; bit0 marks a mid-round cycle.

## Operation
- All outputs are registered. Reset values: `grant`=00, `done`=00, `error`=00, `busy`=0, `core_data_stable`=0, `core_key_ready`=0. Reset also sets state=IDLE, the priority pointer to requester 0, and both counters to 0.
- States: IDLE, GRANT, RUN, DONE, DRAIN.
- IDLE: if any `req` bit is set, grant it. When both are set, the pointer's requester wins. Next state is GRANT.
- GRANT: 1 cycle. Assert `core_data_stable`, clear the timeout and round counters, then go to RUN.
- RUN:
  - `core_data_stable` stays 1.
  - `core_key_ready` = `key_valid[owner]`, registered.
  - The round counter (4 bits, saturating at 15) increments on each cycle with `core_round_type_sel[0]`=1.
  - The timeout counter (7 bits) increments every cycle.
- RUN exits:
  - `core_finished`=1 and round count = `ROUNDS`: go to DONE.
  - `core_finished`=1 and round count ≠ `ROUNDS`: go to DRAIN with an error.
  - Timeout counter = `TIMEOUT_CYCLES`-1 without `core_finished`: go to DRAIN with an error.
  - `core_finished` and timeout in the same cycle: `core_finished` wins and is judged by round count.
- DONE: 1 cycle.
  - Pulse `done[owner]`; drop `core_data_stable`, `core_key_ready` and `grant`.
  - Flip the pointer to the other requester, then go to IDLE.
- DRAIN: 2 cycles.
  - Pulse `error[owner]` in the first cycle.
  - Hold `core_data_stable`=0 and `core_key_ready`=0 so the core returns to its idle state.
  - Drop `grant`, flip the pointer, then go to IDLE.
- Dropping `req[owner]` mid-operation is ignored; the operation completes or errors normally.
- A requester must hold `req` until it sees its done or error pulse. A new request is accepted no earlier than the IDLE cycle that follows.

## Timing
- Request to grant: `req` sampled high in IDLE, `grant` high the next cycle (GRANT).
- Grant to core start: `core_data_stable` rises in the same cycle as `grant` and is seen by the core in the cycle after.
- Finish to done: `core_finished` sampled high in RUN, `done` pulse the next cycle.
- Back-to-back: after DONE, the other waiting requester is granted 2 cycles after the done pulse (DONE→IDLE→GRANT).
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- Async reset mid-operation clears everything immediately. No done or error pulse is issued for the aborted operation.

## Structure
- Shared package `aes_pkg` holds:
  - the state enum (IDLE, GRANT, RUN, DONE, DRAIN);
  - the `AES128_ROUNDS`=10 constant;
  - the counter widths (7-bit timeout, 4-bit round).
- One natural sub-module, `aes_rr_pick`: a combinational two-way round-robin selector taking `req` and the pointer and returning a one-hot pick. Everything else stays in `aes_core_arb`.

## Test plan
- Single request: `req`=01, `key_valid`=01. Core model gives 10 mid-round strobes then `finished`. Expect `grant`=01 one cycle after `req`, then `done`=01 one cycle after `finished`, then `grant`=00.
- Contention: `req`=11 from reset. Expect `grant` sequence 01, then 10, then 01, with `done` pulses alternating 01/10.
- Timeout: `req`=10 and the core never finishes. Expect `error`=10 at RUN cycle 64, then `core_data_stable`=0 for 2 cycles, then `busy`=0.
- Round mismatch: core asserts `finished` after 9 strobes. Expect `error` pulse and no `done`.
- Simultaneous events: `finished` on timeout cycle 63 with 10 strobes. Expect `done`, not `error`.
- Reset mid-RUN: pull `rst_n` low at RUN cycle 5. All outputs are 0 immediately. After release, `req`=01 is granted normally.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core arbiter: FSM state encoding,
// AES-128 round count and counter widths.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RUN,
    ST_DONE,
    ST_DRAIN
  } arb_state_t;

  localparam int AES128_ROUNDS = 10;
  localparam int TO_W          = 7;
  localparam int RND_W         = 4;

endpackage

// File: rtl/aes_rr_pick.sv
// Two-way round-robin selector: returns a one-hot pick from the request vector,
// breaking a tie in favour of the requester named by the priority pointer.
module aes_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) pick = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/aes_core_arb.sv
// Shares one AES core between two requesters: round-robin grant, core handshake
// sequencing, round-count check and a RUN watchdog, with per-requester done/error.
module aes_core_arb
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ROUNDS         = AES128_ROUNDS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] key_valid,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic [1:0] error,
  output logic       busy,
  output logic       core_data_stable,
  output logic       core_key_ready,
  input  logic       core_finished,
  input  logic [1:0] core_round_type_sel
);

  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RND_W-1:0] RND_EXP = RND_W'(ROUNDS);

  arb_state_t       r_state;
  logic             r_ptr;
  logic             r_owner;
  logic             r_drain;
  logic [TO_W-1:0]  r_to_cnt;
  logic [RND_W-1:0] r_round_cnt;
  logic [1:0]       r_grant;
  logic [1:0]       r_done;
  logic [1:0]       r_error;
  logic             r_busy;
  logic             r_data_stable;
  logic             r_key_ready;
  logic [1:0]       w_pick;
  logic             w_unused_sel;

  // Only the mid-round marker matters here; the final-round bit is ignored.
  assign w_unused_sel = core_round_type_sel[1];

  aes_rr_pick u_pick (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= 1'b0;
      r_owner       <= 1'b0;
      r_drain       <= 1'b0;
      r_to_cnt      <= '0;
      r_round_cnt   <= '0;
      r_grant       <= '0;
      r_done        <= '0;
      r_error       <= '0;
      r_busy        <= 1'b0;
      r_data_stable <= 1'b0;
      r_key_ready   <= 1'b0;
    end else begin
      r_done  <= '0;
      r_error <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_grant       <= w_pick;
            r_owner       <= w_pick[1];
            r_data_stable <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_to_cnt    <= '0;
          r_round_cnt <= '0;
          r_key_ready <= key_valid[r_owner];
          r_state     <= ST_RUN;
        end
        ST_RUN: begin
          r_key_ready <= key_valid[r_owner];
          r_to_cnt    <= r_to_cnt + TO_W'(1);
          if (core_round_type_sel[0] && (r_round_cnt != {RND_W{1'b1}}))
            r_round_cnt <= r_round_cnt + RND_W'(1);
          // A finish on the watchdog's last cycle still counts as a finish.
          if (core_finished || (r_to_cnt == TO_LAST)) begin
            r_grant       <= '0;
            r_data_stable <= 1'b0;
            r_key_ready   <= 1'b0;
            if (core_finished && (r_round_cnt == RND_EXP)) begin
              r_done[r_owner] <= 1'b1;
              r_state         <= ST_DONE;
            end else begin
              r_error[r_owner] <= 1'b1;
              r_drain          <= 1'b0;
              r_state          <= ST_DRAIN;
            end
          end
        end
        ST_DONE: begin
          r_ptr   <= ~r_owner;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_DRAIN: begin
          // Two quiet cycles let the core fall back to its own idle state.
          r_drain <= 1'b1;
          if (r_drain) begin
            r_ptr   <= ~r_owner;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant            = r_grant;
  assign done             = r_done;
  assign error            = r_error;
  assign busy             = r_busy;
  assign core_data_stable = r_data_stable;
  assign core_key_ready   = r_key_ready;

endmodule
